gpio_link_arbiter: RTL and testbench
====================================

# gpio_link_arbiter

Sequencer and arbiter that shares one `gpio_protocol` inter-FPGA link between several on-chip message sources. It selects requesters round-robin, latches each 128-bit message and drives the link's `data_ready` / `message_out` handshake. It waits for `done` and returns a per-requester acknowledge. On the receive side it captures each incoming message into a one-deep holding register with a valid/ready handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT_CYC`, default 64: SEND cycles allowed before abort; used only when the timeout feature is compiled in.
- `clock`  in  1  system clock; the same clock that drives the link.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester send request; level, held until `req_ack`/`req_err`.
- `req_msg`  in  NUM_REQ*128  messages; requester i occupies bits [128*i+127:128*i].
- `req_ack`  out  NUM_REQ  one-cycle pulse: requester's message sent.
- `req_err`  out  NUM_REQ  one-cycle pulse: requester's send aborted by timeout.
- `grant_id`  out  $clog2(NUM_REQ)  index currently owning the link.
- `busy`  out  1  high in every state except IDLE.
- `link_data_ready`  out  1  to link `data_ready`.
- `link_message_out`  out  128  to link `message_out`; registered.
- `link_done`  in  1  from link `done`.
- `link_received`  in  1  from link `received`.
- `link_message_in`  in  128  from link `message_in`.
- `rx_valid`  out  1  received message available.
- `rx_message`  out  128  held received message.
- `rx_ready`  in  1  consumer accepts `rx_message`.
- `rx_overflow`  out  1  sticky: a message arrived while `rx_valid` was high.

## Operation
- TX FSM states: IDLE, GRANT, SEND, ACK, GAP.
- IDLE: if any `req` bit is high, choose the winner by round-robin. The search starts at `rr_ptr` and wraps modulo NUM_REQ. Then go to GRANT.
- GRANT: latch `grant_id` and `link_message_out` from the winner's slice, then go to SEND.
- SEND: `link_data_ready`=1.
  - On `link_done`=1, go to ACK.
  - With the timeout feature, on timeout go to ACK with the error flag set.
- ACK:
  - Pulse `req_ack[grant_id]`, or `req_err[grant_id]` if the error flag is set.
  - Drive `link_data_ready`=0.
  - Set `rr_ptr` = (`grant_id`+1) mod NUM_REQ.
  - Go to GAP.
- GAP: hold `link_data_ready` low for one cycle so the link clears its word counter, then go to IDLE.
- After GRANT, a requester dropping `req` does not abort the transfer; it still receives the ack.
- RX path:
  - Edge-detect `link_received` (0→1). On that edge, capture `link_message_in` into `rx_message` and set `rx_valid`.
  - If `rx_valid` is high and not consumed in that cycle, keep the old message and set `rx_overflow`.
  - `rx_valid & rx_ready` clears `rx_valid`.
  - If the edge and the consume happen in the same cycle, the new message loads and `rx_valid` stays 1.
- `rx_overflow` clears only on reset.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; `rr_ptr`=0, edge-detect register 0.
- `req` high in IDLE to `link_data_ready` high: 2 cycles (IDLE→GRANT→SEND).
- `link_done` sampled high to `req_ack` pulse: 1 cycle.
- Minimum spacing between successive transfers: ACK+GAP+IDLE+GRANT = 4 cycles with `link_data_ready` low for at least 2.
- TX and RX operate independently; a receive during SEND is captured normally.
- `resetn` asserted mid-transfer:
  - `link_data_ready` drops immediately (asynchronous).
  - No ack or error is issued.
  - The pending requester must still be holding `req`; it is re-arbitrated after reset.

## Configuration
- `GPIO_ARB_TIMEOUT_EN` defined:
  - An 8-bit or $clog2(TIMEOUT_CYC)+1-bit counter clears on entry to SEND and increments each SEND cycle.
  - When the count reaches TIMEOUT_CYC without `link_done`, SEND exits to ACK and pulses `req_err`.
  - `link_done` and timeout in the same cycle count as success.
- Macro undefined: no counter; SEND waits indefinitely and `req_err` is tied to 0.

## Structure
- Package `gpio_link_pkg`:
  - `MSG_W`=128.
  - Enum `tx_state_t` {IDLE, GRANT, SEND, ACK, GAP}.
  - Default `TIMEOUT_CYC`.
- Sub-module `rr_arbiter`: combinational round-robin picker.
  - Inputs: `req` and `rr_ptr`.
  - Outputs: `gnt_id` and `any_req`.
- The FSM, the RX holding register and the timeout counter stay in `gpio_link_arbiter`.

## Test plan
- `req`=4'b0001, `req_msg[0]`=128'hA5…: `link_data_ready` high 2 cycles later with `link_message_out`=A5…; `link_done` pulse → `req_ack`=4'b0001 one cycle later, then 2+ idle cycles.
- `req`=4'b1111 held, auto-done: grant order is 0,1,2,3,0, each with exactly one ack.
- `req`=4'b0100 after a grant to 3: pointer wraps and requester 2 is granted next; with `req`=4'b1001 after 3, requester 0 is granted.
- RX: `link_received` rises with `link_message_in`=128'h1234 → `rx_valid`=1 and `rx_message`=1234. A second message arrives before `rx_ready` → `rx_overflow`=1 and `rx_message` stays 1234.
- With `GPIO_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8, `link_done` held low: `req_err` pulses after 8 SEND cycles and the next requester is granted. Without the macro, the arbiter stays in SEND.
- `resetn` low during SEND: `link_data_ready`=0 at once, no ack; after release the same `req` is re-granted.

Source files
------------

// File: rtl/gpio_link_pkg.sv
// Shared types and constants for the gpio_protocol link arbiter.
package gpio_link_pkg;
  localparam int MSG_W           = 128;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    SEND  = 3'd2,
    ACK   = 3'd3,
    GAP   = 3'd4
  } tx_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);

  int unsigned idx;

  // Walk from the farthest offset down so the closest requester is written last.
  always_comb begin
    gnt_id  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[ID_W'(idx)]) begin
        gnt_id  = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_link_arbiter.sv
// Shares one gpio_protocol link between NUM_REQ message sources and buffers received messages.
// Optional send timeout compiled in with `define GPIO_ARB_TIMEOUT_EN.
module gpio_link_arbiter
  import gpio_link_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       req_err,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     link_data_ready,
  output logic [MSG_W-1:0]         link_message_out,
  input  logic                     link_done,
  input  logic                     link_received,
  input  logic [MSG_W-1:0]         link_message_in,
  output logic                     rx_valid,
  output logic [MSG_W-1:0]         rx_message,
  input  logic                     rx_ready,
  output logic                     rx_overflow,
  output tx_state_t                tx_state
);

  // Handshakes: a requester holds req until it sees a one-cycle req_ack or req_err;
  // the link sees data_ready high for the whole SEND state; rx_message is taken on
  // any cycle where rx_valid and rx_ready are both high.

  tx_state_t          state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    arb_id;
  logic               any_req;
  logic [MSG_W-1:0]   msg_arr [NUM_REQ];
  logic               rx_prev;
  logic               rx_edge;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
    assign msg_arr[g] = req_msg[g*MSG_W +: MSG_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_id  (arb_id),
    .any_req (any_req)
  );

  assign busy     = (state != IDLE);
  assign tx_state = state;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] to_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign req_err            = '0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      pick_id          <= '0;
      grant_id         <= '0;
      link_data_ready  <= 1'b0;
      link_message_out <= '0;
      req_ack          <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
      req_err          <= '0;
      to_cnt           <= '0;
`endif
    end else begin
      req_ack <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
      req_err <= '0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            pick_id <= arb_id;
            state   <= GRANT;
          end
        end
        GRANT: begin
          grant_id         <= pick_id;
          link_message_out <= msg_arr[pick_id];
          link_data_ready  <= 1'b1;
          state            <= SEND;
`ifdef GPIO_ARB_TIMEOUT_EN
          to_cnt           <= '0;
`endif
        end
        SEND: begin
          // The ack/err pulse is registered here so it is visible during ACK.
          if (link_done) begin
            link_data_ready   <= 1'b0;
            req_ack[grant_id] <= 1'b1;
            state             <= ACK;
          end
`ifdef GPIO_ARB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            link_data_ready   <= 1'b0;
            req_err[grant_id] <= 1'b1;
            state             <= ACK;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ACK: begin
          rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state  <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_edge = link_received & ~rx_prev;

  // A consume in the same cycle as a new arrival frees the slot for it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_prev     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_message  <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_prev <= link_received;
      if (rx_edge) begin
        if (rx_valid && !rx_ready) begin
          rx_overflow <= 1'b1;
        end else begin
          rx_message <= link_message_in;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_link_arbiter.sv
// Randomized self-checking bench for gpio_link_arbiter against a behavioural model.
module tb_gpio_link_arbiter;
  import gpio_link_pkg::*;

  localparam int NR = 4;

  logic                clock = 1'b0;
  logic                resetn = 1'b1;
  logic [NR-1:0]       req = '0;
  logic [NR*MSG_W-1:0] req_msg = '0;
  logic [NR-1:0]       req_ack, req_err;
  logic [1:0]          grant_id;
  logic                busy, link_data_ready;
  logic [MSG_W-1:0]    link_message_out;
  logic                link_done = 1'b0;
  logic                link_received = 1'b0;
  logic [MSG_W-1:0]    link_message_in = '0;
  logic                rx_valid;
  logic [MSG_W-1:0]    rx_message;
  logic                rx_ready = 1'b0;
  logic                rx_overflow;
  tx_state_t           tx_state;

  int errors = 0;
  int checks = 0;
  int rr_model = 0;
  logic [MSG_W-1:0] tx_msgs [NR];
  logic [MSG_W-1:0] exp_q [$];

  gpio_link_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(8)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .req              (req),
    .req_msg          (req_msg),
    .req_ack          (req_ack),
    .req_err          (req_err),
    .grant_id         (grant_id),
    .busy             (busy),
    .link_data_ready  (link_data_ready),
    .link_message_out (link_message_out),
    .link_done        (link_done),
    .link_received    (link_received),
    .link_message_in  (link_message_in),
    .rx_valid         (rx_valid),
    .rx_message       (rx_message),
    .rx_ready         (rx_ready),
    .rx_overflow      (rx_overflow),
    .tx_state         (tx_state)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic reset_dut();
    @(negedge clock);
    resetn = 1'b0;
    req = '0; link_done = 1'b0; link_received = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    rr_model = 0;
  endtask

  // Model: first requester at or after the pointer, counting around the ring.
  function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [MSG_W-1:0] rand_msg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill_random_msgs();
    for (int i = 0; i < NR; i++) tx_msgs[i] = rand_msg();
  endtask

  // Starts and ends at a negedge with the FSM idle.
  task automatic do_transfer(input logic [NR-1:0] pat, input int done_dly, input bit keep,
                             input string name);
    int exp_id;
    for (int i = 0; i < NR; i++) req_msg[i*MSG_W +: MSG_W] = tx_msgs[i];
    exp_id = rr_pick(pat, rr_model);
    req = pat;
    @(negedge clock);
    checks++;
    if (link_data_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_grant: data_ready=%b busy=%b expected 0/1", name, link_data_ready, busy);
    end
    @(negedge clock);
    checks++;
    if (link_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_send: data_ready=%b expected 1", name, link_data_ready);
    end
    checks++;
    if (grant_id !== 2'(exp_id)) begin
      errors++;
      $display("FAIL %s_id: grant_id=%0d expected %0d", name, grant_id, exp_id);
    end
    checks++;
    if (link_message_out !== tx_msgs[exp_id]) begin
      errors++;
      $display("FAIL %s_msg: message_out=%h expected %h", name, link_message_out, tx_msgs[exp_id]);
    end
    if (!keep) req[exp_id] = 1'b0;
    repeat (done_dly) begin
      @(negedge clock);
      checks++;
      if (link_data_ready !== 1'b1 || req_ack !== '0) begin
        errors++;
        $display("FAIL %s_wait: data_ready=%b req_ack=%b expected 1/0000", name,
                 link_data_ready, req_ack);
      end
    end
    link_done = 1'b1;
    @(negedge clock);
    link_done = 1'b0;
    checks++;
    if (req_ack !== 4'(1 << exp_id) || req_err !== '0 || link_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: req_ack=%b req_err=%b data_ready=%b expected %b/0000/0", name,
               req_ack, req_err, link_data_ready, 4'(1 << exp_id));
    end
    @(negedge clock);
    checks++;
    if (req_ack !== '0 || link_data_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_gap: req_ack=%b data_ready=%b busy=%b expected 0000/0/1", name,
               req_ack, link_data_ready, busy);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || link_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b data_ready=%b expected 0/0", name, busy, link_data_ready);
    end
    rr_model = (exp_id + 1) % NR;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ack !== '0 || req_err !== '0 || grant_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx: ack=%b err=%b id=%0d busy=%b expected all 0",
               req_ack, req_err, grant_id, busy);
    end
    checks++;
    if (link_data_ready !== 1'b0 || link_message_out !== '0) begin
      errors++;
      $display("FAIL reset_link: data_ready=%b message_out=%h expected 0", link_data_ready,
               link_message_out);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_message !== '0 || rx_overflow !== 1'b0 || tx_state !== IDLE) begin
      errors++;
      $display("FAIL reset_rx: valid=%b msg=%h ovf=%b state=%0d expected 0/0/0/IDLE",
               rx_valid, rx_message, rx_overflow, tx_state);
    end
  endtask

  task automatic test_single();
    fill_random_msgs();
    tx_msgs[0] = {16{8'hA5}};
    do_transfer(4'b0001, 0, 1'b0, "single");
  endtask

  task automatic test_rr_all();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      fill_random_msgs();
      do_transfer(4'b1111, $urandom_range(0, 2), 1'b1, "rr_all");
    end
    req = '0;
  endtask

  task automatic test_wrap();
    fill_random_msgs();
    do_transfer(4'b1000, 1, 1'b0, "wrap_a3");
    do_transfer(4'b0100, 0, 1'b0, "wrap_b2");
    do_transfer(4'b1000, 2, 1'b0, "wrap_c3");
    do_transfer(4'b1001, 0, 1'b0, "wrap_d0");
  endtask

  task automatic test_random_tx();
    for (int i = 0; i < 12; i++) begin
      fill_random_msgs();
      do_transfer(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  "rand_tx");
    end
    req = '0;
  endtask

  task automatic test_rx_directed();
    link_message_in = 128'h1234;
    link_received   = 1'b1;
    @(negedge clock);
    checks++;
    if (rx_valid !== 1'b1 || rx_message !== 128'h1234 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_first: valid=%b msg=%h ovf=%b expected 1/1234/0", rx_valid,
               rx_message, rx_overflow);
    end
    link_received = 1'b0;
    @(negedge clock);
    link_message_in = 128'h5678;
    link_received   = 1'b1;
    @(negedge clock);
    checks++;
    if (rx_valid !== 1'b1 || rx_message !== 128'h1234 || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL rx_overflow: valid=%b msg=%h ovf=%b expected 1/1234/1", rx_valid,
               rx_message, rx_overflow);
    end
    link_received = 1'b0;
    rx_ready      = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL rx_consume: valid=%b ovf=%b expected 0/1", rx_valid, rx_overflow);
    end
  endtask

`ifdef GPIO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    int n_send;
    fill_random_msgs();
    for (int i = 0; i < NR; i++) req_msg[i*MSG_W +: MSG_W] = tx_msgs[i];
    w = rr_pick(4'b0011, rr_model);
    req = 4'b0011;
    repeat (2) @(negedge clock);
    n_send = (link_data_ready === 1'b1) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (link_data_ready !== 1'b1) break;
      n_send++;
    end
    checks++;
    if (n_send != 8) begin
      errors++;
      $display("FAIL timeout_len: send_cycles=%0d expected 8", n_send);
    end
    checks++;
    if (req_err !== 4'(1 << w) || req_ack !== '0) begin
      errors++;
      $display("FAIL timeout_err: req_err=%b req_ack=%b expected %b/0000", req_err, req_ack,
               4'(1 << w));
    end
    req[w] = 1'b0;
    repeat (2) @(negedge clock);
    rr_model = (w + 1) % NR;
    fill_random_msgs();
    do_transfer(4'b0011, 0, 1'b0, "after_timeout");
  endtask
`endif

  // Holds a send open, receives during it, then resets mid-transfer.
  task automatic test_send_hold_and_reset();
    logic [MSG_W-1:0] rmsg;
    fill_random_msgs();
    for (int i = 0; i < NR; i++) req_msg[i*MSG_W +: MSG_W] = tx_msgs[i];
    req = 4'b0010;
    repeat (2) @(negedge clock);
    checks++;
    if (link_data_ready !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL hold_send: data_ready=%b id=%0d expected 1/1", link_data_ready, grant_id);
    end
    rmsg = rand_msg();
    link_message_in = rmsg;
    link_received   = 1'b1;
    @(negedge clock);
    checks++;
    if (rx_valid !== 1'b1 || rx_message !== rmsg || link_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_during_send: valid=%b msg=%h dr=%b expected 1/%h/1", rx_valid,
               rx_message, link_data_ready, rmsg);
    end
    link_received = 1'b0;
    rx_ready      = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
`ifndef GPIO_ARB_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      checks++;
      if (tx_state !== SEND || link_data_ready !== 1'b1 || req_err !== '0 || req_ack !== '0) begin
        errors++;
        $display("FAIL hang: state=%0d dr=%b err=%b ack=%b expected SEND/1/0000/0000",
                 tx_state, link_data_ready, req_err, req_ack);
      end
    end
`endif
    resetn = 1'b0;
    #1;
    checks++;
    if (link_data_ready !== 1'b0 || req_ack !== '0 || req_err !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dr=%b ack=%b err=%b busy=%b expected 0", link_data_ready,
               req_ack, req_err, busy);
    end
    @(negedge clock);
    checks++;
    if (req_ack !== '0 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ack=%b ovf=%b expected 0000/0", req_ack, rx_overflow);
    end
    resetn   = 1'b1;
    rr_model = 0;
    do_transfer(4'b0010, 1, 1'b0, "regrant");
    req = '0;
  endtask

  task automatic test_rx_random();
    logic rec, rdy, prev;
    logic [MSG_W-1:0] m;
    bit   ovf;
    prev = 1'b0;
    ovf  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      rec = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      m   = rand_msg();
      if (rec && !prev) begin
        if (exp_q.size() > 0 && !rdy) ovf = 1'b1;
        else begin
          exp_q.delete();
          exp_q.push_back(m);
        end
      end else if (exp_q.size() > 0 && rdy) begin
        void'(exp_q.pop_front());
      end
      prev            = rec;
      link_received   = rec;
      rx_ready        = rdy;
      link_message_in = m;
      @(negedge clock);
      checks++;
      if (rx_valid !== (exp_q.size() > 0) || rx_overflow !== ovf ||
          (exp_q.size() > 0 && rx_message !== exp_q[0])) begin
        errors++;
        $display("FAIL rx_rand: valid=%b ovf=%b msg=%h expected %b/%b/%h", rx_valid,
                 rx_overflow, rx_message, exp_q.size() > 0, ovf,
                 (exp_q.size() > 0) ? exp_q[0] : '0);
      end
    end
    link_received = 1'b0;
    rx_ready      = 1'b0;
  endtask

  initial begin
    reset_dut();
    test_reset();
    test_single();
    test_rr_all();
    test_wrap();
    test_random_tx();
    test_rx_directed();
`ifdef GPIO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_send_hold_and_reset();
    test_rx_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
